// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single memory port between NUM_REQ requesters.
// One access in flight at a time; each access ends in a response, or in an error on timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_SIZE    = 16,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
    output logic                          o_rsp_err,
    output logic                          o_mem_wr,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
    input  logic                          i_mem_rsp
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [GW-1:0]         r_last;
    logic [GW-1:0]         r_grant;
    logic                  r_wr;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_found;
    logic [GW-1:0]         w_gnt;
    logic [GW-1:0]         w_idx;
    logic                  w_req_wr;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [DATA_WIDTH-1:0] w_req_wdata;
    logic                  w_in_range;
    logic                  w_timeout;
    logic                  w_accept;

    // Search starts one past the last grant and wraps, so the last winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            w_idx = GW'((32'(r_last) + 32'(i)) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_req_wr    = i_req_wr[w_gnt];
    assign w_req_addr  = i_req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_req_wdata = i_req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_in_range  = (32'(w_req_addr) < MEM_SIZE);
    assign w_timeout   = (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_accept    = (r_state == StIdle) && w_found && !i_reset;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_d = w_in_range ? StAccess : StResp;
                end
            end
            StAccess: begin
                if (i_mem_rsp || w_timeout) begin
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last      <= GW'(NUM_REQ - 1);
            r_grant     <= '0;
            r_wr        <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_grant <= w_gnt;
                        r_last  <= w_gnt;
                        r_wr    <= w_req_wr;
                        r_cnt   <= '0;
                        // Out-of-range requests never reach the memory port, which keeps its old value.
                        if (w_in_range) begin
                            r_mem_addr  <= w_req_addr;
                            r_mem_wdata <= w_req_wdata;
                        end else begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_rsp) begin
                        r_rsp_rdata <= r_wr ? '0 : i_mem_rdata;
                        r_rsp_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = w_accept ? (NUM_REQ'(1) << w_gnt) : '0;
    assign o_rsp_valid = (r_state == StResp) ? (NUM_REQ'(1) << r_grant) : '0;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_wr    = (r_state == StAccess) && r_wr;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a responding memory model plus a scoreboard that predicts
// each response (requester, data, error, cycle) at the moment the request is accepted.
module tb_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MS = 16;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_wr = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             mem_wr;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic             mem_rsp = 1'b0;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_SIZE   (MS),
        .NUM_REQ    (NR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req_valid(req_valid),
        .i_req_wr   (req_wr),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_err  (rsp_err),
        .o_mem_wr   (mem_wr),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .i_mem_rsp  (mem_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          mem_delay = 0;   // ACCESS cycles before mem_rsp; negative = never respond
    logic [7:0]  tb_addr [NR];
    logic [31:0] tb_data [NR];
    logic        tb_wr [NR];
    logic [31:0] rmem [MS];
    logic [31:0] smem [MS];
    exp_t        sb[$];
    int          grant_log[$];
    int          mg;
    exp_t        me;
    int          acc = 0;
    bit          active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: tracks the access started by each in-range grant.
    always @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            acc    <= 0;
            for (int k = 0; k < MS; k++) rmem[k] <= 32'hA500_0000 + 32'(k);
        end else if (active) begin
            if (mem_rsp) begin
                if (mem_wr) rmem[mem_addr[3:0]] <= mem_wdata;
                active <= 1'b0;
            end else if (acc >= TO) begin
                active <= 1'b0;
            end else begin
                acc <= acc + 1;
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (req_ready[k] && tb_addr[k] < 8'(MS)) begin
                    active <= 1'b1;
                    acc    <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        mem_rsp   = active && (mem_delay >= 0) && (acc - 1 == mem_delay);
        mem_rdata = active ? rmem[mem_addr[3:0]] : 32'hFFFF_FFFF;
    end

    // Scoreboard: predict on accept, compare on completion.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            for (int k = 0; k < MS; k++) smem[k] = 32'hA500_0000 + 32'(k);
        end else begin
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                mg = 0;
                for (int k = 0; k < NR; k++) if (req_ready[k]) mg = k;
                grant_log.push_back(mg);
                me.idx = mg;
                if (tb_addr[mg] >= 8'(MS)) begin
                    me.rdata = '0;
                    me.err   = 1'b1;
                    me.due   = cyc + 1;
                end else if (mem_delay < 0 || mem_delay > TO - 1) begin
                    me.rdata = '0;
                    me.err   = 1'b1;
                    me.due   = cyc + 1 + TO;
                end else begin
                    me.err = 1'b0;
                    me.due = cyc + 2 + mem_delay;
                    if (tb_wr[mg]) begin
                        me.rdata = '0;
                        smem[tb_addr[mg][3:0]] = tb_data[mg];
                    end else begin
                        me.rdata = smem[tb_addr[mg][3:0]];
                    end
                end
                sb.push_back(me);
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    me = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << me.idx));
                    chk("rsp_rdata", rsp_rdata, me.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(me.err));
                    chk("rsp_cycle", 32'(cyc), 32'(me.due));
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                chk("rsp_late", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d);
        tb_wr[i]              = wr;
        tb_addr[i]            = a;
        tb_data[i]            = d;
        req_wr[i]             = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_ready(input int i, input int max);
        int n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready[i]), 32'd1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order[6];
        int base;
        int n;
        exp_order = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < NR; k++) begin
            tb_addr[k] = '0;
            tb_data[k] = '0;
            tb_wr[k]   = 1'b0;
        end

        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Single write from req1, memory responds one cycle after ACCESS entry.
        step();
        mem_delay = 1;
        drive_req(1, 1'b1, 8'h05, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("t1_mem_wr", 32'(mem_wr), 32'd1);
            chk("t1_mem_addr", 32'(mem_addr), 32'h05);
            chk("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        chk("t1_rsp", 32'(rsp_valid), 32'h2);
        drain(10);
        drive_req(1, 1'b0, 8'h05, 32'h0);
        wait_ready(1, 20);
        step();
        req_valid[1] = 1'b0;
        drain(40);

        // All requesters reading continuously: round-robin from requester 0.
        do_reset();
        mem_delay = 0;
        base = grant_log.size();
        for (int k = 0; k < NR; k++) drive_req(k, 1'b0, 8'(k), 32'h1000 + 32'(k));
        n = 0;
        while (grant_log.size() < base + 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rr_count", 32'(grant_log.size() - base), 32'd6);
        step();
        req_valid = '0;
        drain(40);
        for (int k = 0; k < 6; k++) begin
            if (base + k < grant_log.size()) chk("rr_order", 32'(grant_log[base + k]), 32'(exp_order[k]));
        end

        // Out-of-range address: error without touching the memory port.
        drive_req(2, 1'b0, 8'h10, 32'h5555_5555);
        wait_ready(2, 20);
        step();
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("oor_mem_wr", 32'(mem_wr), 32'd0);
        chk("oor_mem_addr", 32'(mem_addr), 32'h01);
        chk("oor_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("oor_rsp_err", 32'(rsp_err), 32'd1);
        drain(10);

        // Memory never answers: timeout error, then normal service resumes.
        mem_delay = -1;
        drive_req(0, 1'b0, 8'h03, 32'h0);
        wait_ready(0, 20);
        step();
        req_valid[0] = 1'b0;
        drain(40);
        mem_delay = 2;
        drive_req(3, 1'b1, 8'h04, 32'hCAFE_F00D);
        wait_ready(3, 20);
        step();
        req_valid[3] = 1'b0;
        drain(40);
        drive_req(0, 1'b0, 8'h04, 32'h0);
        wait_ready(0, 20);
        step();
        req_valid[0] = 1'b0;
        drain(40);

        // Response arrives in the same cycle the timeout expires: response wins.
        mem_delay = TO - 1;
        drive_req(1, 1'b0, 8'h02, 32'h0);
        wait_ready(1, 20);
        step();
        req_valid[1] = 1'b0;
        drain(40);

        // Reset in the middle of an access aborts it silently.
        mem_delay = -1;
        drive_req(3, 1'b0, 8'h06, 32'h0);
        wait_ready(3, 20);
        step();
        req_valid[3] = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_delay = 0;
        drive_req(0, 1'b0, 8'h07, 32'h0);
        drive_req(3, 1'b0, 8'h08, 32'h0);
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'h1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        chk("abort_rsp_err", 32'(rsp_err), 32'd0);
        chk("abort_mem_wr", 32'(mem_wr), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        step();
        req_valid[0] = 1'b0;
        wait_ready(3, 20);
        step();
        req_valid[3] = 1'b0;
        drain(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
